led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Parametrised, double-buffered, PWM-dimmed LED matrix scan driver for the comprocboard matrix display. Holds two NUM_ROWS×NUM_COLS pixel buffers of PWM_BITS intensity each. Scans one row at a time with blanking between rows, and swaps front and back buffers only at frame boundaries. Sits between the CPU's memory-mapped peripheral bus and the board's row and column pins, replacing the fixed 8×8 on/off driver.

## Interface
- NUM_ROWS, 8, number of scanned rows (≥2)
- NUM_COLS, 8, number of column lines (≥1)
- PWM_BITS, 4, pixel intensity width; one PWM period is 2^PWM_BITS−1 steps
- PRESCALE, 4, clock cycles per PWM step (≥1)
- BLANK_CYCLES, 2, all-off cycles before each row is driven (≥1)
- ROW_ACTIVE_LOW, 0, invert row outputs
- COL_ACTIVE_LOW, 0, invert column outputs
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_row  in  $clog2(NUM_ROWS)  target row; values ≥NUM_ROWS are accepted and dropped
- wr_col  in  $clog2(NUM_COLS)  target column; values ≥NUM_COLS are accepted and dropped
- wr_value  in  PWM_BITS  intensity
- swap_req  in  1  one-cycle request to swap buffers at the next frame boundary
- swap_done  out  1  one-cycle pulse when a swap takes effect
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- row  out  NUM_ROWS  row drive, one-hot while driving
- col  out  NUM_COLS  column drive

## Operation
- FSM states: BLANK and DRIVE. A row counter r, a PWM step counter k, and a prescale counter p.
- **BLANK:** lasts BLANK_CYCLES cycles. All rows and all columns are inactive. The next state is DRIVE.
- **DRIVE:**
  - Lasts PRESCALE×(2^PWM_BITS−1) cycles.
  - row = onehot(r).
  - col[c] is active iff front[r][c] > k, with k running 0 … 2^PWM_BITS−2.
  - Value 0 is never lit. Value 2^PWM_BITS−1 is lit for all of DRIVE.
  - At the end of DRIVE, r increments (wrapping NUM_ROWS−1 → 0) and the FSM returns to BLANK.
- **Frame boundary:** the first BLANK cycle of row 0.
  - frame_start = 1 on this cycle.
  - If swap_pending was set at the end of the previous cycle, the front/back select toggles, swap_done = 1, and swap_pending clears. This cycle's row 0 then scans the new front buffer.
- **Writes:**
  - Accepted writes go to the back buffer only.
  - wr_ready = !swap_pending, so writes stall while a swap is pending.
  - A write and a swap_req in the same cycle: the write is accepted into the current back buffer, and pending is set afterwards.
- **swap_req handling:**
  - swap_req while already pending has no effect.
  - swap_req on a frame-boundary cycle sets pending; the swap happens at the next boundary.
- **After a swap:** the back buffer holds the previous front contents. No copy or clear is performed.
- **Polarity:** ROW_ACTIVE_LOW and COL_ACTIVE_LOW invert the respective outputs at the pins only.

## Timing
- **Reset values:**
  - row and col inactive, i.e. all 0, or all 1 if the active-low parameter is set.
  - frame_start = 0, swap_done = 0, wr_ready = 0.
  - Both buffers all 0, front select = buffer 0, swap_pending = 0.
- **First cycle after reset deasserts:**
  - The FSM is in BLANK of row 0, with frame_start = 1 and wr_ready = 1.
  - No swap occurs on this cycle.
- **Registered outputs:** all outputs are registered. A pixel accepted in cycle t is visible in the back buffer at t+1.
- **Frame length:**
  - Row period = BLANK_CYCLES + PRESCALE×(2^PWM_BITS−1).
  - Frame = NUM_ROWS × row period.
  - Defaults: 62 cycles per row, 496 per frame.
- **Reset mid-frame:** state returns immediately to the reset values above. Buffer contents are cleared and pending swaps are discarded.

## Structure
- **Package led_matrix_pkg:**
  - scan_state_t enum (BLANK, DRIVE).
  - Helper functions for row period and frame length, used by both RTL and bench.
- **Sub-module led_matrix_pixel_buffer:**
  - Two register banks, a toggle select, and a write port to the back bank.
  - A combinational read of the front bank indexed by r.
- **Top level:** FSM, the p/k/r counters, the swap handshake, and the output polarity logic.

## Test plan
- **Reset and idle:** hold reset 2 cycles, release.
  - Row and col stay 0 through the first BLANK cycles.
  - frame_start pulses at cycle 0 and again at cycles 496 and 992.
  - wr_ready = 1 from cycle 0.
- **Full intensity:** write value 15 to (2,5), then swap_req.
  - swap_done coincides with the next frame_start.
  - Then row = 8'b0000_0100 and col = 8'b0010_0000 for all 60 DRIVE cycles of row 2.
  - Col is 0 during the 2 BLANK cycles.
- **PWM duty:** value 3 at (0,0) after a swap → col[0] is high for exactly 12 of the 60 DRIVE cycles (k = 0, 1, 2), and low otherwise.
- **Swap stall:** swap_req at cycle 10, then hold wr_valid high.
  - wr_ready = 0 from cycle 11 until the boundary at cycle 496, where swap_done = 1.
  - The held write is accepted at cycle 496 into the new back buffer; it is not displayed until the next swap.
- **Simultaneous events:**
  - swap_req on a frame_start cycle → the swap is deferred one full frame.
  - A second swap_req while pending → exactly one swap_done.
- **Polarity and reset mid-frame:** ROW_ACTIVE_LOW = 1 inverts row only. Asserting reset during DRIVE of row 4 restores all reset values on the next cycle and clears the buffers.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and timing helpers for the LED matrix scan driver.
// The frame-timing functions are the single source for both the design and its bench.
package led_matrix_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pwm_steps(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

  function automatic int count_width(input int prescale, input int blank_cycles);
    return addr_width((prescale > blank_cycles) ? prescale : blank_cycles);
  endfunction

  function automatic int row_period(input int blank_cycles, input int prescale,
                                    input int pwm_bits);
    return blank_cycles + prescale * pwm_steps(pwm_bits);
  endfunction

  function automatic int frame_length(input int num_rows, input int blank_cycles,
                                      input int prescale, input int pwm_bits);
    return num_rows * row_period(blank_cycles, prescale, pwm_bits);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// CPU-side pixel write and buffer swap port of the LED matrix scanner.
interface led_matrix_scanner_if
  import led_matrix_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8,
  parameter int PWM_BITS = 4
);

  localparam int ROW_W = addr_width(NUM_ROWS);
  localparam int COL_W = addr_width(NUM_COLS);

  logic                wr_valid;
  logic                wr_ready;
  logic [ROW_W-1:0]    wr_row;
  logic [COL_W-1:0]    wr_col;
  logic [PWM_BITS-1:0] wr_value;
  logic                swap_req;
  logic                swap_done;

  modport master (
    output wr_valid, wr_row, wr_col, wr_value, swap_req,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_value, swap_req,
    output wr_ready, swap_done
  );

endinterface

// File: rtl/led_matrix_pixel_buffer.sv
// Two pixel banks with a front/back select; writes land in the back bank,
// the scanner reads one row of the front bank combinationally.
module led_matrix_pixel_buffer
  import led_matrix_pkg::*;
#(
  parameter int  NUM_ROWS = 8,
  parameter int  NUM_COLS = 8,
  parameter int  PWM_BITS = 4,
  localparam int ROW_W    = addr_width(NUM_ROWS),
  localparam int COL_W    = addr_width(NUM_COLS)
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_swap,
  input  logic                               i_wr_en,
  input  logic [ROW_W-1:0]                   i_wr_row,
  input  logic [COL_W-1:0]                   i_wr_col,
  input  logic [PWM_BITS-1:0]                i_wr_value,
  input  logic [ROW_W-1:0]                   i_rd_row,
  output logic [NUM_COLS-1:0][PWM_BITS-1:0]  o_rd_data
);

  logic                r_sel;
  logic [PWM_BITS-1:0] r_bank [2][NUM_ROWS][NUM_COLS];
  logic                w_wr_hit;

  // Out-of-range coordinates are accepted on the bus but never stored.
  assign w_wr_hit = i_wr_en && (int'(i_wr_row) < NUM_ROWS) && (int'(i_wr_col) < NUM_COLS);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sel <= 1'b0;
      // NOTE: both banks must read as zero after reset, so they are built from
      // resettable flops and cannot be mapped onto a block RAM.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          for (int c = 0; c < NUM_COLS; c++) begin
            r_bank[b][r][c] <= '0;
          end
        end
      end
    end else begin
      if (w_wr_hit) begin
        r_bank[!r_sel][i_wr_row][i_wr_col] <= i_wr_value;
      end
      if (i_swap) begin
        r_sel <= !r_sel;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      o_rd_data[c] = r_bank[r_sel][i_rd_row][c];
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered, PWM-dimmed row scanner: BLANK/DRIVE FSM, prescale/step/row
// counters, frame-aligned buffer swap and pin polarity. Every output is registered.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int NUM_ROWS       = 8,
  parameter int NUM_COLS       = 8,
  parameter int PWM_BITS       = 4,
  parameter int PRESCALE       = 4,
  parameter int BLANK_CYCLES   = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  led_matrix_scanner_if.slave  bus,
  output logic [NUM_ROWS-1:0]  o_row,
  output logic [NUM_COLS-1:0]  o_col,
  output logic                 o_frame_start
);

  localparam int ROW_W = addr_width(NUM_ROWS);
  localparam int CNT_W = count_width(PRESCALE, BLANK_CYCLES);

  localparam logic [CNT_W-1:0]    LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    LAST_PRE   = CNT_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] LAST_K     = PWM_BITS'(pwm_steps(PWM_BITS) - 1);
  localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [NUM_ROWS-1:0] ROW_IDLE   = {NUM_ROWS{ROW_ACTIVE_LOW}};
  localparam logic [NUM_COLS-1:0] COL_IDLE   = {NUM_COLS{COL_ACTIVE_LOW}};

  scan_state_t         r_state, w_state;
  logic                r_run;
  logic [ROW_W-1:0]    r_r, w_r;
  logic [PWM_BITS-1:0] r_k, w_k;
  logic [CNT_W-1:0]    r_p, w_p;
  logic                r_pending, w_pending;
  logic                r_wr_ready;
  logic                r_swap_done;
  logic                r_frame_start;
  logic [NUM_ROWS-1:0] r_row, w_row_act;
  logic [NUM_COLS-1:0] r_col, w_col_act;

  logic                w_boundary;
  logic                w_req;
  logic                w_swap;
  logic                w_accept;
  logic [NUM_COLS-1:0][PWM_BITS-1:0] w_front;

  // The counters describe the cycle being shown; r_run parks them at the
  // start of row 0 for the first cycle out of reset.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state = r_state;
    w_r     = r_r;
    w_k     = r_k;
    w_p     = r_p;
    if (!r_run) begin
      w_state = BLANK;
      w_r     = '0;
      w_k     = '0;
      w_p     = '0;
    end else begin
      unique case (r_state)
        BLANK: begin
          if (r_p == LAST_BLANK) begin
            w_state = DRIVE;
            w_p     = '0;
            w_k     = '0;
          end else begin
            w_p = r_p + 1'b1;
          end
        end
        DRIVE: begin
          if (r_p == LAST_PRE) begin
            w_p = '0;
            if (r_k == LAST_K) begin
              w_k     = '0;
              w_state = BLANK;
              w_r     = (r_r == LAST_ROW) ? '0 : r_r + 1'b1;
            end else begin
              w_k = r_k + 1'b1;
            end
          end else begin
            w_p = r_p + 1'b1;
          end
        end
        default: w_state = BLANK;
      endcase
    end
  end

  // A request arriving on the edge into a boundary still counts for that boundary.
  assign w_boundary = (w_state == BLANK) && (w_r == '0) && (w_p == '0);
  assign w_req      = r_run && bus.swap_req;
  assign w_swap     = r_run && w_boundary && (r_pending || w_req);
  assign w_pending  = w_swap ? 1'b0 : (r_pending || w_req);
  assign w_accept   = bus.wr_valid && r_wr_ready;

  led_matrix_pixel_buffer #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .PWM_BITS (PWM_BITS)
  ) u_buffer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_swap     (w_swap),
    .i_wr_en    (w_accept),
    .i_wr_row   (bus.wr_row),
    .i_wr_col   (bus.wr_col),
    .i_wr_value (bus.wr_value),
    .i_rd_row   (w_r),
    .o_rd_data  (w_front)
  );

  always_comb begin
    w_row_act = '0;
    w_col_act = '0;
    if (w_state == DRIVE) begin
      w_row_act = NUM_ROWS'(1) << w_r;
      for (int c = 0; c < NUM_COLS; c++) begin
        w_col_act[c] = (w_front[c] > w_k);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      r_run         <= 1'b0;
      r_state       <= BLANK;
      r_r           <= '0;
      r_k           <= '0;
      r_p           <= '0;
      r_pending     <= 1'b0;
      r_wr_ready    <= 1'b0;
      r_swap_done   <= 1'b0;
      r_frame_start <= 1'b0;
      r_row         <= ROW_IDLE;
      r_col         <= COL_IDLE;
    end else begin
      r_run         <= 1'b1;
      r_state       <= w_state;
      r_r           <= w_r;
      r_k           <= w_k;
      r_p           <= w_p;
      r_pending     <= w_pending;
      r_wr_ready    <= !w_pending;
      r_swap_done   <= w_swap;
      r_frame_start <= w_boundary;
      r_row         <= w_row_act ^ ROW_IDLE;
      r_col         <= w_col_act ^ COL_IDLE;
    end
  end

  assign bus.wr_ready  = r_wr_ready;
  assign bus.swap_done = r_swap_done;
  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: reset, PWM, swap handshake, polarity, mid-frame reset.
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  localparam int NR    = 8;
  localparam int NC    = 8;
  localparam int PB    = 4;
  localparam int PS    = 4;
  localparam int BL    = 2;
  localparam int ROWP  = row_period(BL, PS, PB);
  localparam int FRAME = frame_length(NR, BL, PS, PB);

  logic          clk;
  logic          rst;
  logic [NR-1:0] row, row_p;
  logic [NC-1:0] col, col_p;
  logic          fs, fs_p;
  int            vectors;
  int            miscompares;
  int            cyc;

  led_matrix_scanner_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .PWM_BITS(PB)) bus ();
  led_matrix_scanner_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .PWM_BITS(PB)) bus_p ();

  led_matrix_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .PWM_BITS(PB), .PRESCALE(PS), .BLANK_CYCLES(BL),
    .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus),
    .o_row(row), .o_col(col), .o_frame_start(fs)
  );

  led_matrix_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .PWM_BITS(PB), .PRESCALE(PS), .BLANK_CYCLES(BL),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
  ) dut_p (
    .i_clock(clk), .i_reset(rst), .bus(bus_p),
    .o_row(row_p), .o_col(col_p), .o_frame_start(fs_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected scan position of cycle n, counted from the first cycle out of reset.
  function automatic logic [NR-1:0] exp_row(input int n);
    logic [NR-1:0] one;
    one = 1;
    if ((n % ROWP) < BL) return '0;
    return one << ((n % FRAME) / ROWP);
  endfunction

  function automatic bit drive_of(input int n, input int r);
    return ((n % ROWP) >= BL) && (((n % FRAME) / ROWP) == r);
  endfunction

  function automatic int k_of(input int n);
    return ((n % ROWP) - BL) / PS;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    cyc = 0;
  endtask

  task automatic write_px(input int r, input int c, input int v);
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'(r);
    bus.wr_col   = 3'(c);
    bus.wr_value = 4'(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (row !== 8'h00) begin miscompares++; $display("FAIL rst_row got=%h exp=00", row); end
    vectors++; if (col !== 8'h00) begin miscompares++; $display("FAIL rst_col got=%h exp=00", col); end
    vectors++; if (fs !== 1'b0) begin miscompares++; $display("FAIL rst_frame_start got=%b exp=0", fs); end
    vectors++; if (bus.swap_done !== 1'b0) begin miscompares++; $display("FAIL rst_swap_done got=%b exp=0", bus.swap_done); end
    vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready got=%b exp=0", bus.wr_ready); end
    vectors++; if (row_p !== 8'hFF) begin miscompares++; $display("FAIL rst_row_low got=%h exp=ff", row_p); end
    rst = 1'b0;
    step();
    cyc = 0;
    while (cyc <= 2 * FRAME) begin
      vectors++; if (fs !== (cyc % FRAME == 0)) begin miscompares++; $display("FAIL idle_frame_start cyc=%0d got=%b exp=%b", cyc, fs, (cyc % FRAME == 0)); end
      vectors++; if (row !== exp_row(cyc)) begin miscompares++; $display("FAIL idle_row cyc=%0d got=%h exp=%h", cyc, row, exp_row(cyc)); end
      vectors++; if (col !== 8'h00) begin miscompares++; $display("FAIL idle_col cyc=%0d got=%h exp=00", cyc, col); end
      vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL idle_wr_ready cyc=%0d got=%b exp=1", cyc, bus.wr_ready); end
      vectors++; if (bus.swap_done !== 1'b0) begin miscompares++; $display("FAIL idle_swap_done cyc=%0d got=%b exp=0", cyc, bus.swap_done); end
      step();
    end
  endtask

  task automatic test_full_intensity();
    logic [NC-1:0] e;
    apply_reset();
    write_px(2, 5, 15);
    step();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    while (cyc < FRAME) begin
      vectors++; if (bus.swap_done !== 1'b0) begin miscompares++; $display("FAIL full_early_swap cyc=%0d got=%b exp=0", cyc, bus.swap_done); end
      step();
    end
    vectors++; if (bus.swap_done !== 1'b1) begin miscompares++; $display("FAIL full_swap_done cyc=%0d got=%b exp=1", cyc, bus.swap_done); end
    vectors++; if (fs !== 1'b1) begin miscompares++; $display("FAIL full_frame_start cyc=%0d got=%b exp=1", cyc, fs); end
    while (cyc < FRAME + 3 * ROWP) begin
      e = drive_of(cyc, 2) ? 8'h20 : 8'h00;
      vectors++; if (col !== e) begin miscompares++; $display("FAIL full_col cyc=%0d got=%h exp=%h", cyc, col, e); end
      vectors++; if (row !== exp_row(cyc)) begin miscompares++; $display("FAIL full_row cyc=%0d got=%h exp=%h", cyc, row, exp_row(cyc)); end
      step();
    end
  endtask

  task automatic test_pwm_duty();
    int lit;
    bit e;
    lit = 0;
    apply_reset();
    write_px(0, 0, 3);
    step();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    while (cyc < FRAME) step();
    while (cyc < FRAME + ROWP) begin
      e = drive_of(cyc, 0) && (k_of(cyc) < 3);
      vectors++; if (col[0] !== e) begin miscompares++; $display("FAIL pwm_col0 cyc=%0d got=%b exp=%b", cyc, col[0], e); end
      vectors++; if (col[NC-1:1] !== '0) begin miscompares++; $display("FAIL pwm_other_cols cyc=%0d got=%h exp=00", cyc, col); end
      if (col[0] === 1'b1) lit++;
      step();
    end
    vectors++; if (lit !== 12) begin miscompares++; $display("FAIL pwm_lit_count got=%0d exp=12", lit); end
  endtask

  task automatic test_swap_stall();
    logic [NC-1:0] e;
    apply_reset();
    while (cyc < 10) begin
      vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_pre cyc=%0d got=%b exp=1", cyc, bus.wr_ready); end
      step();
    end
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    write_px(1, 1, 9);
    while (cyc < FRAME) begin
      vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, bus.wr_ready); end
      step();
    end
    vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_release cyc=%0d got=%b exp=1", cyc, bus.wr_ready); end
    vectors++; if (bus.swap_done !== 1'b1) begin miscompares++; $display("FAIL stall_swap_done cyc=%0d got=%b exp=1", cyc, bus.swap_done); end
    step();
    bus.wr_valid = 1'b0;
    while (cyc < 2 * FRAME + 2 * ROWP) begin
      if (cyc == 500) bus.swap_req = 1'b1;
      if (cyc == 501) bus.swap_req = 1'b0;
      e = (drive_of(cyc, 1) && cyc >= 2 * FRAME && k_of(cyc) < 9) ? 8'h02 : 8'h00;
      vectors++; if (col !== e) begin miscompares++; $display("FAIL stall_col cyc=%0d got=%h exp=%h", cyc, col, e); end
      vectors++; if (bus.swap_done !== (cyc == 2 * FRAME)) begin miscompares++; $display("FAIL stall_swap2 cyc=%0d got=%b exp=%b", cyc, bus.swap_done, (cyc == 2 * FRAME)); end
      step();
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    bit e;
    pulses = 0;
    apply_reset();
    while (cyc <= 2 * FRAME + 10) begin
      e = (cyc == FRAME) || (cyc == 2 * FRAME);
      vectors++; if (bus.swap_done !== e) begin miscompares++; $display("FAIL simul_swap_done cyc=%0d got=%b exp=%b", cyc, bus.swap_done, e); end
      if (bus.swap_done === 1'b1) pulses++;
      // Requests on both frame_start cycles and a duplicate while pending.
      bus.swap_req = (cyc == 0) || (cyc == 5) || (cyc == FRAME);
      step();
    end
    bus.swap_req = 1'b0;
    vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL simul_pulse_count got=%0d exp=2", pulses); end
  endtask

  task automatic test_polarity();
    apply_reset();
    while (cyc < 2 * ROWP) begin
      vectors++; if (row_p !== ~exp_row(cyc)) begin miscompares++; $display("FAIL pol_row_low cyc=%0d got=%h exp=%h", cyc, row_p, ~exp_row(cyc)); end
      vectors++; if (col_p !== 8'h00) begin miscompares++; $display("FAIL pol_col cyc=%0d got=%h exp=00", cyc, col_p); end
      vectors++; if (row !== exp_row(cyc)) begin miscompares++; $display("FAIL pol_row_high cyc=%0d got=%h exp=%h", cyc, row, exp_row(cyc)); end
      vectors++; if (fs_p !== (cyc == 0)) begin miscompares++; $display("FAIL pol_frame_start cyc=%0d got=%b exp=%b", cyc, fs_p, (cyc == 0)); end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    write_px(4, 3, 15);
    step();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    while (cyc < 760) begin
      bus.swap_req = (cyc == 700);
      step();
    end
    bus.swap_req = 1'b0;
    vectors++; if (row !== 8'h10) begin miscompares++; $display("FAIL mid_row_before got=%h exp=10", row); end
    vectors++; if (col !== 8'h08) begin miscompares++; $display("FAIL mid_col_before got=%h exp=08", col); end
    rst = 1'b1;
    step();
    vectors++; if (row !== 8'h00) begin miscompares++; $display("FAIL mid_rst_row got=%h exp=00", row); end
    vectors++; if (col !== 8'h00) begin miscompares++; $display("FAIL mid_rst_col got=%h exp=00", col); end
    vectors++; if (fs !== 1'b0) begin miscompares++; $display("FAIL mid_rst_frame_start got=%b exp=0", fs); end
    vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wr_ready got=%b exp=0", bus.wr_ready); end
    vectors++; if (bus.swap_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_swap_done got=%b exp=0", bus.swap_done); end
    vectors++; if (row_p !== 8'hFF) begin miscompares++; $display("FAIL mid_rst_row_low got=%h exp=ff", row_p); end
    rst = 1'b0;
    step();
    cyc = 0;
    vectors++; if (fs !== 1'b1) begin miscompares++; $display("FAIL mid_restart_frame_start got=%b exp=1", fs); end
    vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL mid_restart_wr_ready got=%b exp=1", bus.wr_ready); end
    while (cyc < 2 * FRAME + 5 * ROWP) begin
      bus.swap_req = (cyc == 500);
      vectors++; if (col !== 8'h00) begin miscompares++; $display("FAIL mid_cleared_col cyc=%0d got=%h exp=00", cyc, col); end
      vectors++; if (bus.swap_done !== (cyc == 2 * FRAME)) begin miscompares++; $display("FAIL mid_swap_done cyc=%0d got=%b exp=%b", cyc, bus.swap_done, (cyc == 2 * FRAME)); end
      step();
    end
    bus.swap_req = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_row   = '0;
    bus.wr_col   = '0;
    bus.wr_value = '0;
    bus.swap_req = 1'b0;
    bus_p.wr_valid = 1'b0;
    bus_p.wr_row   = '0;
    bus_p.wr_col   = '0;
    bus_p.wr_value = '0;
    bus_p.swap_req = 1'b0;
    #1;
    test_reset();
    test_full_intensity();
    test_pwm_duty();
    test_swap_stall();
    test_simultaneous();
    test_polarity();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
